// File: rtl/result_pkg.sv
// -----------------------------------------------------------------------------
// result_pkg
// Shared definitions for the result slot allocator:
//   - slot_state_e : allocator FSM states (INIT, ARMED, STALLED)
//   - DEF_*        : default ring geometry (slot count, stride, base address)
// -----------------------------------------------------------------------------
package result_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    ARMED   = 2'd1,
    STALLED = 2'd2
  } slot_state_e;

  localparam int              DEF_NUM_SLOTS   = 5;
  localparam longint unsigned DEF_SLOT_STRIDE = 64'd1550;
  localparam longint unsigned DEF_BASE_ADDR   = 64'd0;

endpackage

// File: rtl/result_slot_ptr.sv
// -----------------------------------------------------------------------------
// result_slot_ptr
// Wrapping slot index with a matching base-address accumulator. The address is
// maintained incrementally (add stride, reload base on wrap) so no multiplier
// is needed; addr always equals BASE_ADDR + idx*SLOT_STRIDE.
// Ports:
//   clk   in   clock, rising edge
//   n_rst in   asynchronous active-low reset (idx = 0, addr = BASE_ADDR)
//   adv   in   advance to the next slot (wraps NUM_SLOTS-1 -> 0)
//   idx   out  current slot index (registered)
//   addr  out  current slot base address (registered)
// -----------------------------------------------------------------------------
module result_slot_ptr #(
  parameter int              NUM_SLOTS   = 5,
  parameter longint unsigned SLOT_STRIDE = 64'd1550,
  parameter longint unsigned BASE_ADDR   = 64'd0,
  parameter int              ADDR_W      = 32,
  parameter int              IDX_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              adv,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(SLOT_STRIDE);

  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (adv) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        addr_d = BASE;
      end else begin
        idx_d  = idx_q + 1'b1;
        addr_d = addr_q + STRIDE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_q  <= '0;
      addr_q <= BASE;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign idx  = idx_q;
  assign addr = addr_q;

endmodule

// File: rtl/result_slot_allocator.sv
// -----------------------------------------------------------------------------
// result_slot_allocator
// Hands the result writer a base address per record in a ring of NUM_SLOTS
// equally spaced slots, tracks slots consumed by the reader, and stalls the
// writer instead of overwriting unread results.
// Ports:
//   clk          in   clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   inc_addr     in   writer commits its slot and requests the next one
//   release_slot in   reader has finished the oldest committed slot
//   addr_out     out  base address of the slot owned by the writer
//   write_enable out  one-cycle pulse when the writer is granted a slot
//   rd_addr      out  base address of the oldest committed slot
//   count        out  committed, unreleased slots (0..NUM_SLOTS)
//   full         out  all slots committed, writer owns no slot
//   overflow     out  one-cycle pulse: inc_addr while writer owned no slot
//   underflow    out  one-cycle pulse: release_slot with count == 0
// All outputs are registered.
// -----------------------------------------------------------------------------
module result_slot_allocator
  import result_pkg::*;
#(
  parameter int              NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter longint unsigned SLOT_STRIDE = DEF_SLOT_STRIDE,
  parameter longint unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int              ADDR_W      = 32,
  localparam int             CNT_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              inc_addr,
  input  logic              release_slot,
  output logic [ADDR_W-1:0] addr_out,
  output logic              write_enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int              IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SLOTS);
  localparam longint unsigned LAST_ADDR = BASE_ADDR + longint'(NUM_SLOTS - 1) * SLOT_STRIDE;

  // Reject geometries that cannot be represented.
  if (NUM_SLOTS < 2) begin : g_bad_slots
    $error("result_slot_allocator: NUM_SLOTS must be >= 2");
  end
  if ((LAST_ADDR >> ADDR_W) != 0) begin : g_bad_range
    $error("result_slot_allocator: last slot address does not fit in ADDR_W bits");
  end

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we_q, we_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_adv, rd_adv;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_adv  = 1'b0;
    rd_adv  = 1'b0;

    case (state_q)
      INIT: begin
        // Writer is granted slot 0 unconditionally; it owns nothing yet.
        state_d = ARMED;
        we_d    = 1'b1;
        ovf_d   = inc_addr;
        unf_d   = release_slot;
      end

      ARMED: begin
        if (inc_addr && release_slot && (count_q != '0)) begin
          // Commit and release balance out: count unchanged, never stalls.
          wr_adv = 1'b1;
          rd_adv = 1'b1;
          we_d   = 1'b1;
        end else begin
          if (release_slot) begin
            if (count_q == '0) begin
              unf_d = 1'b1;
            end else begin
              count_d = count_q - 1'b1;
              rd_adv  = 1'b1;
            end
          end
          if (inc_addr) begin
            count_d = count_q + 1'b1;
            wr_adv  = 1'b1;
            if ((count_q + 1'b1) == CNT_FULL) begin
              state_d = STALLED;
            end else begin
              we_d = 1'b1;
            end
          end
        end
      end

      STALLED: begin
        ovf_d = inc_addr;
        if (release_slot) begin
          // Writer takes over the freed slot; wr_idx already points at it.
          count_d = count_q - 1'b1;
          rd_adv  = 1'b1;
          state_d = ARMED;
          we_d    = 1'b1;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign full_d = (state_d == STALLED);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= INIT;
      count_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  result_slot_ptr #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_STRIDE(SLOT_STRIDE),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W)
  ) u_wr_ptr (
    .clk  (clk),
    .n_rst(n_rst),
    .adv  (wr_adv),
    .idx  (wr_idx),
    .addr (addr_out)
  );

  result_slot_ptr #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_STRIDE(SLOT_STRIDE),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W)
  ) u_rd_ptr (
    .clk  (clk),
    .n_rst(n_rst),
    .adv  (rd_adv),
    .idx  (rd_idx),
    .addr (rd_addr)
  );

  // A full ring means the writer has caught up with the reader.
  a_stall_idx : assert property (@(posedge clk) disable iff (!n_rst)
                                 (state_q == STALLED) |-> (wr_idx == rd_idx));

  assign write_enable = we_q;
  assign count        = count_q;
  assign full         = full_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_result_slot_allocator.sv
module tb_result_slot_allocator;

  logic        clk;
  logic        n_rst;

  // Default-geometry DUT (5 slots, stride 1550, base 0)
  logic        inc_addr, release_slot;
  logic [31:0] addr_out, rd_addr;
  logic        write_enable, full, overflow, underflow;
  logic [2:0]  count;

  // Parameter-sweep DUT (2 slots, stride 64, base 0x1000)
  logic        p_inc, p_rel;
  logic [31:0] p_addr, p_rd_addr;
  logic        p_we, p_full, p_ovf, p_unf;
  logic [1:0]  p_count;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [31:0] seq_exp [5];

  result_slot_allocator dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .inc_addr    (inc_addr),
    .release_slot(release_slot),
    .addr_out    (addr_out),
    .write_enable(write_enable),
    .rd_addr     (rd_addr),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  result_slot_allocator #(
    .NUM_SLOTS  (2),
    .SLOT_STRIDE(64'd64),
    .BASE_ADDR  (64'h1000),
    .ADDR_W     (32)
  ) dut_p (
    .clk         (clk),
    .n_rst       (n_rst),
    .inc_addr    (p_inc),
    .release_slot(p_rel),
    .addr_out    (p_addr),
    .write_enable(p_we),
    .rd_addr     (p_rd_addr),
    .count       (p_count),
    .full        (p_full),
    .overflow    (p_ovf),
    .underflow   (p_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t inc=%0b rel=%0b | addr=%h we=%0b rd=%h cnt=%0d full=%0b ovf=%0b unf=%0b | p_addr=%h p_we=%0b p_cnt=%0d",
             $time, inc_addr, release_slot, addr_out, write_enable, rd_addr, count,
             full, overflow, underflow, p_addr, p_we, p_count);
  endtask

  // Reset both DUTs, release mid-cycle, then let INIT -> ARMED happen.
  task automatic do_reset();
    inc_addr = 0; release_slot = 0; p_inc = 0; p_rel = 0;
    n_rst = 0;
    #2;
    n_rst = 1;
    tick();
  endtask

  task automatic test_reset();
    inc_addr = 0; release_slot = 0; p_inc = 0; p_rel = 0;
    n_rst = 0;
    #12;
    check_cnt++;
    if ({addr_out, rd_addr, count, write_enable, full, overflow, underflow} !== {32'h0, 32'h0, 3'd0, 4'b0000})
      $display("FAIL reset_values got addr=%h rd=%h cnt=%0d we=%0b full=%0b ovf=%0b unf=%0b want all zero",
               addr_out, rd_addr, count, write_enable, full, overflow, underflow);
    else pass_cnt++;
    @(negedge clk);
    n_rst = 1;
    tick();
    check_cnt++;
    if ({write_enable, addr_out, count, full} !== {1'b1, 32'h0, 3'd0, 1'b0})
      $display("FAIL first_grant got we=%0b addr=%h cnt=%0d full=%0b want we=1 addr=0 cnt=0 full=0",
               write_enable, addr_out, count, full);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (write_enable !== 1'b0)
      $display("FAIL idle_we got %0b want 0", write_enable);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({write_enable, addr_out} !== {1'b0, 32'h0})
      $display("FAIL idle_hold got we=%0b addr=%h want we=0 addr=0", write_enable, addr_out);
    else pass_cnt++;
  endtask

  task automatic test_addr_sequence();
    seq_exp[0] = 32'h060E; seq_exp[1] = 32'h0C1C; seq_exp[2] = 32'h122A;
    seq_exp[3] = 32'h1838; seq_exp[4] = 32'h0000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      inc_addr = 1;
      tick();
      inc_addr = 0;
      check_cnt++;
      if ({write_enable, addr_out, count} !== {1'b1, seq_exp[i], 3'd1})
        $display("FAIL seq_grant%0d got we=%0b addr=%h cnt=%0d want we=1 addr=%h cnt=1",
                 i, write_enable, addr_out, count, seq_exp[i]);
      else pass_cnt++;
      release_slot = 1;
      tick();
      release_slot = 0;
      check_cnt++;
      if ({write_enable, rd_addr, count} !== {1'b0, seq_exp[i], 3'd0})
        $display("FAIL seq_release%0d got we=%0b rd=%h cnt=%0d want we=0 rd=%h cnt=0",
                 i, write_enable, rd_addr, count, seq_exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill_stall();
    do_reset();
    inc_addr = 1;   // held as a level: one commit per cycle
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_cnt++;
      if ({write_enable, count, full} !== {1'b1, 3'(i), 1'b0})
        $display("FAIL fill%0d got we=%0b cnt=%0d full=%0b want we=1 cnt=%0d full=0",
                 i, write_enable, count, full, i);
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if ({write_enable, count, full, addr_out, overflow} !== {1'b0, 3'd5, 1'b1, 32'h0, 1'b0})
      $display("FAIL stall_entry got we=%0b cnt=%0d full=%0b addr=%h ovf=%0b want we=0 cnt=5 full=1 addr=0 ovf=0",
               write_enable, count, full, addr_out, overflow);
    else pass_cnt++;
    tick();
    inc_addr = 0;
    check_cnt++;
    if ({overflow, count, full, write_enable} !== {1'b1, 3'd5, 1'b1, 1'b0})
      $display("FAIL overflow got ovf=%0b cnt=%0d full=%0b we=%0b want ovf=1 cnt=5 full=1 we=0",
               overflow, count, full, write_enable);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({overflow, rd_addr} !== {1'b0, 32'h0})
      $display("FAIL overflow_pulse got ovf=%0b rd=%h want ovf=0 rd=0", overflow, rd_addr);
    else pass_cnt++;
    release_slot = 1;
    tick();
    release_slot = 0;
    check_cnt++;
    if ({rd_addr, count, full, write_enable, addr_out} !== {32'h060E, 3'd4, 1'b0, 1'b1, 32'h0})
      $display("FAIL stall_release got rd=%h cnt=%0d full=%0b we=%0b addr=%h want rd=060e cnt=4 full=0 we=1 addr=0",
               rd_addr, count, full, write_enable, addr_out);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    inc_addr = 1;
    tick();
    tick();
    inc_addr = 0;
    check_cnt++;
    if ({count, addr_out, rd_addr} !== {3'd2, 32'h0C1C, 32'h0})
      $display("FAIL simul_setup got cnt=%0d addr=%h rd=%h want cnt=2 addr=0c1c rd=0", count, addr_out, rd_addr);
    else pass_cnt++;
    inc_addr = 1; release_slot = 1;
    tick();
    inc_addr = 0; release_slot = 0;
    check_cnt++;
    if ({count, addr_out, rd_addr, write_enable, underflow} !== {3'd2, 32'h122A, 32'h060E, 1'b1, 1'b0})
      $display("FAIL simul got cnt=%0d addr=%h rd=%h we=%0b unf=%0b want cnt=2 addr=122a rd=060e we=1 unf=0",
               count, addr_out, rd_addr, write_enable, underflow);
    else pass_cnt++;
  endtask

  task automatic test_underflow_reset();
    do_reset();
    release_slot = 1;
    tick();
    release_slot = 0;
    check_cnt++;
    if ({underflow, count, rd_addr, write_enable} !== {1'b1, 3'd0, 32'h0, 1'b0})
      $display("FAIL underflow got unf=%0b cnt=%0d rd=%h we=%0b want unf=1 cnt=0 rd=0 we=0",
               underflow, count, rd_addr, write_enable);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (underflow !== 1'b0)
      $display("FAIL underflow_pulse got %0b want 0", underflow);
    else pass_cnt++;
    // Both at count 0: release ignored, inc handled alone.
    inc_addr = 1; release_slot = 1;
    tick();
    inc_addr = 0; release_slot = 0;
    check_cnt++;
    if ({underflow, count, write_enable, addr_out, rd_addr} !== {1'b1, 3'd1, 1'b1, 32'h060E, 32'h0})
      $display("FAIL both_at_zero got unf=%0b cnt=%0d we=%0b addr=%h rd=%h want unf=1 cnt=1 we=1 addr=060e rd=0",
               underflow, count, write_enable, addr_out, rd_addr);
    else pass_cnt++;
    inc_addr = 1;
    for (int i = 0; i < 4; i++) tick();
    inc_addr = 0;
    check_cnt++;
    if ({full, count} !== {1'b1, 3'd5})
      $display("FAIL restall got full=%0b cnt=%0d want full=1 cnt=5", full, count);
    else pass_cnt++;
    #3;
    n_rst = 0;
    #1;
    check_cnt++;
    if ({addr_out, rd_addr, count, write_enable, full, overflow, underflow} !== {32'h0, 32'h0, 3'd0, 4'b0000})
      $display("FAIL async_reset got addr=%h rd=%h cnt=%0d we=%0b full=%0b ovf=%0b unf=%0b want all zero",
               addr_out, rd_addr, count, write_enable, full, overflow, underflow);
    else pass_cnt++;
    @(negedge clk);
    n_rst = 1;
    tick();
    check_cnt++;
    if ({write_enable, count, full} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL post_reset_grant got we=%0b cnt=%0d full=%0b want we=1 cnt=0 full=0",
               write_enable, count, full);
    else pass_cnt++;
  endtask

  task automatic test_param_sweep();
    do_reset();
    check_cnt++;
    if ({p_we, p_addr, p_rd_addr} !== {1'b1, 32'h1000, 32'h1000})
      $display("FAIL p_init got we=%0b addr=%h rd=%h want we=1 addr=1000 rd=1000", p_we, p_addr, p_rd_addr);
    else pass_cnt++;
    p_inc = 1;
    tick();
    check_cnt++;
    if ({p_we, p_addr, p_count, p_full} !== {1'b1, 32'h1040, 2'd1, 1'b0})
      $display("FAIL p_inc1 got we=%0b addr=%h cnt=%0d full=%0b want we=1 addr=1040 cnt=1 full=0",
               p_we, p_addr, p_count, p_full);
    else pass_cnt++;
    tick();
    p_inc = 0;
    check_cnt++;
    if ({p_we, p_addr, p_count, p_full} !== {1'b0, 32'h1000, 2'd2, 1'b1})
      $display("FAIL p_stall got we=%0b addr=%h cnt=%0d full=%0b want we=0 addr=1000 cnt=2 full=1",
               p_we, p_addr, p_count, p_full);
    else pass_cnt++;
    p_rel = 1;
    tick();
    p_rel = 0;
    check_cnt++;
    if ({p_we, p_rd_addr, p_count, p_full} !== {1'b1, 32'h1040, 2'd1, 1'b0})
      $display("FAIL p_release got we=%0b rd=%h cnt=%0d full=%0b want we=1 rd=1040 cnt=1 full=0",
               p_we, p_rd_addr, p_count, p_full);
    else pass_cnt++;
    p_inc = 1; p_rel = 1;
    tick();
    p_inc = 0; p_rel = 0;
    check_cnt++;
    if ({p_addr, p_rd_addr, p_count, p_we} !== {32'h1040, 32'h1000, 2'd1, 1'b1})
      $display("FAIL p_both got addr=%h rd=%h cnt=%0d we=%0b want addr=1040 rd=1000 cnt=1 we=1",
               p_addr, p_rd_addr, p_count, p_we);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addr_sequence();
    test_fill_stall();
    test_simultaneous();
    test_underflow_reset();
    test_param_sweep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/result_slot_allocator.md
# result_slot_allocator

Parametrised output-buffer slot allocator for the sniffer result path. It sits between the match/packet writer and the output FIFO memory, and hands the writer a base address for each result record in a ring of NUM_SLOTS equally spaced slots. Unlike a free-running rotator, it tracks which slots the downstream reader has consumed and stalls the writer rather than overwrite unread results. It also exports the reader's current slot address and an overflow indication.

## Interface
- NUM_SLOTS, 5: number of slots in the ring; must be ≥ 2.
- SLOT_STRIDE, 1550: address distance between consecutive slots.
- BASE_ADDR, 0: address of slot 0.
- ADDR_W, 32: width of both address outputs. BASE_ADDR + (NUM_SLOTS-1)*SLOT_STRIDE must be < 2^ADDR_W; this is an elaboration-time check.
- CNT_W, $clog2(NUM_SLOTS+1): width of `count`; derived, not overridden.
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- inc_addr  in  1  writer has finished its current slot: commit it and request the next slot.
- release_slot  in  1  reader has finished the oldest committed slot.
- addr_out  out  ADDR_W  base address of the slot currently owned by the writer.
- write_enable  out  1  one-cycle pulse when the writer is granted a new slot.
- rd_addr  out  ADDR_W  base address of the oldest committed slot.
- count  out  CNT_W  number of committed, unreleased slots (0..NUM_SLOTS).
- full  out  1  high while all slots are committed and the writer owns no slot.
- overflow  out  1  one-cycle pulse: inc_addr arrived while the writer owned no slot.
- underflow  out  1  one-cycle pulse: release_slot arrived with count == 0.

## Operation
- State machine with three states: INIT, ARMED, STALLED.
- Internal state: write index wr_idx, read index rd_idx, and `count`.
- INIT
  - Entered only from reset.
  - Always goes to ARMED on the next edge and raises write_enable for slot 0.
- ARMED (the writer owns slot wr_idx)
  - inc_addr alone: count+1, wr_idx advances with wrap.
    - If the new count == NUM_SLOTS: go to STALLED, no write_enable.
    - Otherwise: pulse write_enable with the new addr_out.
  - release_slot alone, count > 0: count-1, rd_idx advances with wrap; stay in ARMED.
  - Both together, count > 0: count unchanged, both indices advance, pulse write_enable. Never stall in this case.
  - Both together, count == 0: the release is ignored (underflow pulse), then inc_addr is handled as if it arrived alone. This case can never reach STALLED.
- STALLED (wr_idx == rd_idx, count == NUM_SLOTS)
  - full = 1; addr_out holds the last granted address.
  - inc_addr: overflow pulse; no other effect.
  - release_slot: count-1, rd_idx advances, go to ARMED and pulse write_enable. The writer is handed the freed slot; wr_idx and addr_out are unchanged.
- Index wrap: NUM_SLOTS-1 → 0.
- Address arithmetic is incremental: add SLOT_STRIDE, and on wrap reload BASE_ADDR. No multiplier is used.
- addr_out always equals BASE_ADDR + wr_idx*SLOT_STRIDE.
- rd_addr always equals BASE_ADDR + rd_idx*SLOT_STRIDE.

## Timing
- Reset values:
  - state INIT, wr_idx = rd_idx = 0, count = 0.
  - addr_out = rd_addr = BASE_ADDR.
  - write_enable = full = overflow = underflow = 0.
- First rising edge after reset release: state ARMED, write_enable = 1 for exactly one cycle.
- All outputs are registered.
- Inputs sampled at edge k take effect in the cycle after edge k (1-cycle latency). write_enable is high for exactly that cycle.
- A reset assertion at any time, including in STALLED or mid-pulse, immediately forces all reset values. Partially committed state is discarded.
- inc_addr held high for several cycles is treated as one event per cycle; a level is not a single request.

## Structure
- Package result_pkg holds:
  - the state enum (INIT, ARMED, STALLED);
  - the default constants (default slot count, default stride, default base).
- One sub-module, result_slot_ptr: wrapping index plus address accumulator, with parameters NUM_SLOTS, SLOT_STRIDE, BASE_ADDR, ADDR_W.
  - Instantiated twice: write pointer and read pointer.
  - Ports: clk, n_rst, adv, idx, addr.

## Test plan
Defaults apply unless stated.
- **Reset then idle:** first cycle after reset has write_enable = 1 and addr_out = 0x0000, with count = 0 and full = 0; write_enable is 0 thereafter.
- **Address sequence:** apply 4 inc_addr pulses, each with an interleaved release_slot on the next cycle. addr_out steps 0x060E, 0xC1C, 0x122A, 0x1838, with one write_enable pulse per step. A 5th inc_addr/release pair wraps addr_out to 0x0000.
- **Fill to stall:** apply 5 inc_addr pulses with no release. After the 5th: full = 1, count = 5, no write_enable, addr_out = 0x0000.
  - A further inc_addr produces overflow = 1 for one cycle.
  - Then release_slot produces: rd_addr 0x0000 → 0x060E, count = 4, full = 0, write_enable pulse with addr_out = 0x0000.
- **Simultaneous events:** at count = 2, inc_addr and release_slot in the same cycle → count stays 2, addr_out and rd_addr each advance one stride, write_enable pulses.
- **Underflow and mid-stall reset:** release_slot at count 0 → underflow pulse, no state change. Reset asserted in STALLED → all outputs return to reset values asynchronously.
- **Parameter sweep:** NUM_SLOTS = 2, SLOT_STRIDE = 64, BASE_ADDR = 0x1000 → addresses alternate 0x1000 / 0x1040, and the ring stalls after 2 commits.
